// File: rtl/imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// imem_loader: receives a length-prefixed, XOR-checksummed byte image, writes it
// into the MIPS instruction memory and releases the core once the image verifies.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_rst_n,
  output logic        busy,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  len_hi;
  logic [15:0] word_cnt;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [7:0]  xor_acc;
  logic [23:0] shift;
  logic        xfer;
  logic        start_ok;
  logic        word_end;
  logic [15:0] len_in;

  assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CHECK);
  assign busy       = byte_ready;
  assign xfer       = byte_valid & byte_ready;
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign len_in     = {len_hi, byte_data};
  assign word_end   = (byte_cnt == 2'd3);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if ({1'b0, len_in} > DEPTH_W) state_nxt = S_ERROR;
          else if (len_in == 16'd0)     state_nxt = S_CHECK;
          else                          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && word_end && (word_idx == word_cnt - 16'd1)) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (xfer) state_nxt = (byte_data == xor_acc) ? S_DONE : S_ERROR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len_hi     <= 8'd0;
      word_cnt   <= 16'd0;
      word_idx   <= 16'd0;
      byte_cnt   <= 2'd0;
      xor_acc    <= 8'd0;
      shift      <= 24'd0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wd    <= 32'd0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      // Release the core one cycle after DONE is entered; drop it on the start edge.
      core_rst_n <= (state == S_DONE) && (state_nxt == S_DONE);
      load_done  <= (state_nxt == S_DONE);
      load_err   <= (state_nxt == S_ERROR);

      if (start_ok) begin
        word_idx <= 16'd0;
        byte_cnt <= 2'd0;
        xor_acc  <= 8'd0;
      end

      if (xfer) begin
        unique case (state)
          S_LEN_HI: len_hi   <= byte_data;
          S_LEN_LO: word_cnt <= len_in;
          S_DATA: begin
            xor_acc  <= xor_acc ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], byte_data};
            if (word_end) begin
              imem_we   <= 1'b1;
              imem_addr <= {14'd0, word_idx, 2'b00};
              imem_wd   <= {shift, byte_data};
              word_idx  <= word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for imem_loader: streams images against a queue-based
// model of the expected memory writes and final load status.
module tb_imem_loader;

  localparam int DEPTH = 64;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        core_rst_n;
  logic        busy;
  logic        load_done;
  logic        load_err;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wd    (imem_wd),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];
  wr_t mon_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every write the DUT issues must be the next one the model predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write", imem_addr, imem_wd);
        end else begin
          mon_w = exp_q.pop_front();
          chk("write_addr", imem_addr, mon_w.addr);
          chk("write_data", imem_wd, mon_w.data);
        end
      end
      chk("core_held_while_busy", {31'd0, core_rst_n & busy}, 32'd0);
      chk("done_err_exclusive", {31'd0, load_done & load_err}, 32'd0);
    end
  end

  // outcome: 0 = checksum good, 1 = checksum bad, 2 = length too large
  task automatic model(input byte_q_t s, output int outcome, output logic [7:0] xr);
    int  n;
    wr_t e;
    n  = int'({s[0], s[1]});
    xr = 8'd0;
    if (n > DEPTH) begin
      outcome = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      e.addr = 32'(4 * k);
      e.data = {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]};
      xr = xr ^ s[2+4*k] ^ s[3+4*k] ^ s[4+4*k] ^ s[5+4*k];
      exp_q.push_back(e);
    end
    outcome = (s[2+4*n] == xr) ? 0 : 1;
  endtask

  task automatic make_stream(input int n, input bit good, output byte_q_t s);
    logic [7:0] xr;
    logic [7:0] b;
    logic [15:0] n16;
    n16 = 16'(n);
    s = {};
    s.push_back(n16[15:8]);
    s.push_back(n16[7:0]);
    xr = 8'd0;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      xr ^= b;
      s.push_back(b);
    end
    s.push_back(good ? xr : ~xr);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offers bytes in order; returns after the edge that takes the last one.
  task automatic send(input byte_q_t s, input bit rnd, input int max_cyc,
                      output int consumed, output int cycles);
    int i;
    bit xfer;
    i = 0;
    cycles = 0;
    while (i < s.size() && cycles < max_cyc) begin
      @(negedge clk);
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = s[i];
      start      = rnd && byte_ready && ($urandom_range(0, 3) == 0);
      xfer       = byte_valid && byte_ready;
      @(posedge clk);
      #1 start = 1'b0;
      if (xfer) i++;
      cycles++;
    end
    byte_valid = 1'b0;
    consumed = i;
  endtask

  task automatic run_load(input byte_q_t s, input bit rnd);
    int outcome, consumed, cycles, n, max_cyc;
    logic [7:0] xr;
    model(s, outcome, xr);
    n = int'({s[0], s[1]});
    max_cyc = rnd ? (20 * s.size() + 20) : (s.size() + 4);
    do_start();
    send(s, rnd, max_cyc, consumed, cycles);
    if (outcome == 2) begin
      chk("len_err_consumed", 32'(consumed), 32'd2);
    end else begin
      chk("bytes_consumed", 32'(consumed), 32'(s.size()));
      if (!rnd) chk("load_cycles", 32'(cycles), 32'(4 * n + 3));
    end
    @(negedge clk);
    chk("load_done_t1", {31'd0, load_done}, {31'd0, outcome == 0});
    chk("load_err_t1", {31'd0, load_err}, {31'd0, outcome != 0});
    chk("ready_after_load", {31'd0, byte_ready}, 32'd0);
    chk("core_rst_t1", {31'd0, core_rst_n}, 32'd0);
    chk("writes_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("core_rst_t2", {31'd0, core_rst_n}, {31'd0, outcome == 0});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_wd"}, imem_wd, 32'd0);
    chk({tag, "_flags"}, {28'd0, core_rst_n, busy, load_done, load_err}, 32'd0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t s;
    int oc, consumed, cycles;
    logic [7:0] xr;
    wr_t e;

    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_no_ready", {31'd0, byte_ready}, 32'd0);
    end
    byte_valid = 1'b0;

    // Directed image; the XOR of its eight data bytes is 0x8D.
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04, 8'h8D};
    model(s, oc, xr);
    chk("model_xor", {24'd0, xr}, 32'h8D);
    chk("model_outcome_good", 32'(oc), 32'd0);
    chk("model_w0", exp_q[0].data, 32'h20080005);
    chk("model_w1_addr", exp_q[1].addr, 32'd4);
    chk("model_w1", exp_q[1].data, 32'hAC080004);
    exp_q.delete();
    run_load(s, 1'b0);

    s[10] = 8'h24;
    model(s, oc, xr);
    chk("model_outcome_bad", 32'(oc), 32'd1);
    exp_q.delete();
    run_load(s, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("core_held_on_err", {31'd0, core_rst_n}, 32'd0);
    end

    s = '{8'h00, 8'h41, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load(s, 1'b0);

    // Three words with bubbles and ignored start pulses, then the same image back to back.
    make_stream(3, 1'b1, s);
    run_load(s, 1'b1);
    run_load(s, 1'b0);

    make_stream(DEPTH, 1'b1, s);
    run_load(s, 1'b0);
    make_stream(1, 1'b1, s);
    run_load(s, 1'b0);
    for (int it = 0; it < 6; it++) begin
      make_stream(int'($urandom_range(1, 6)), ($urandom_range(0, 3) != 0), s);
      run_load(s, 1'b1);
    end

    s = '{8'h00, 8'h00, 8'h00};
    model(s, oc, xr);
    chk("model_outcome_empty", 32'(oc), 32'd0);
    run_load(s, 1'b0);
    do_start();
    @(negedge clk);
    chk("restart_core_rst", {31'd0, core_rst_n}, 32'd0);
    chk("restart_done_clear", {31'd0, load_done}, 32'd0);
    chk("restart_ready", {31'd0, byte_ready}, 32'd1);

    // Abort a load with reset after the first word has been written.
    s = '{8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12};
    e.addr = 32'd0;
    e.data = 32'hDEADBEEF;
    exp_q.push_back(e);
    send(s, 1'b0, s.size() + 4, consumed, cycles);
    chk("partial_consumed", 32'(consumed), 32'd7);
    byte_valid = 1'b1;
    rst_n = 1'b0;
    #1 check_reset_outputs("midload_rst");
    chk("midload_writes_seen", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_ready", {31'd0, byte_ready}, 32'd0);
    end
    byte_valid = 1'b0;

    make_stream(2, 1'b1, s);
    run_load(s, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
